// File: rtl/clock_div.sv
// clock_div: phase-accumulator rate generator.
// Produces single-cycle o_clk strobes at an average rate of FREQUENCY pulses
// per second from an i_clk running at I_CLK_FRQ Hz. Consumers treat o_clk as
// a clock enable sampled on i_clk, never as a clock of its own.
//
// Each cycle the accumulator advances by FREQUENCY. When the running sum
// reaches I_CLK_FRQ, one pulse is due: the accumulator keeps only the
// remainder and o_clk registers high for one cycle. Pulses therefore arrive
// every floor or ceil of I_CLK_FRQ/FREQUENCY cycles, with no run-time
// division.
//
// Two degenerate rates are resolved at elaboration:
//   FREQUENCY == 0           -> o_clk never pulses, accumulator stays 0.
//   FREQUENCY >= I_CLK_FRQ   -> o_clk is high every cycle, accumulator stays 0.
module clock_div #(
  parameter int I_CLK_FRQ = 100_000_000,
  parameter int FREQUENCY = 9600
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_clk
);

  // Wide enough that acc_q + FREQUENCY never wraps: acc_q stays below
  // I_CLK_FRQ, so the largest sum is under I_CLK_FRQ + FREQUENCY.
  localparam int ACC_W = $clog2(I_CLK_FRQ + FREQUENCY) + 1;

  // Fixed step and wrap constants, sized to the accumulator.
  localparam logic [ACC_W-1:0] STEP_C = ACC_W'(FREQUENCY);
  localparam logic [ACC_W-1:0] WRAP_C = ACC_W'(I_CLK_FRQ);

  // Rate mode, decided once at elaboration.
  localparam bit ZERO_RATE = (FREQUENCY == 0);
  localparam bit FULL_RATE = (FREQUENCY >= I_CLK_FRQ);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;
  logic             wrap;
  logic             o_clk_q;
  logic             o_clk_d;

  // Next-phase computation: advance, then fold back once a pulse is due.
  always_comb begin
    sum     = acc_q + STEP_C;
    wrap    = (sum >= WRAP_C);
    acc_d   = sum;
    o_clk_d = 1'b0;
    if (FULL_RATE) begin
      acc_d   = '0;
      o_clk_d = 1'b1;
    end else if (ZERO_RATE) begin
      acc_d   = '0;
      o_clk_d = 1'b0;
    end else if (wrap) begin
      acc_d   = sum - WRAP_C;
      o_clk_d = 1'b1;
    end
  end

  // Phase and strobe registers; reset clears both without waiting for a clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q   <= '0;
      o_clk_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      o_clk_q <= o_clk_d;
    end
  end

  // The strobe leaves straight from its flop.
  assign o_clk = o_clk_q;

endmodule

// File: tb/tb_clock_div.sv
// tb_clock_div: several clock_div instances with different rate settings run
// side by side from one clock and one reset. Expected strobes come from the
// closed-form pulse count floor(k*F/I): a pulse follows edge k exactly when
// that count steps up between edge k-1 and edge k.
module tb_clock_div;

  localparam int N_DUT = 6;

  // Per-instance settings: 8/2, 10/3, 4/4, 4/0, 4/6, and the defaults.
  localparam longint I_TAB [N_DUT] = '{8, 10, 4, 4, 4, 100_000_000};
  localparam longint F_TAB [N_DUT] = '{2, 3, 4, 0, 6, 9600};

  logic             clk;
  logic             rst;
  logic [N_DUT-1:0] o_vec;

  // ---------------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  clock_div #(.I_CLK_FRQ(8),  .FREQUENCY(2)) u_div_8_2  (.i_clk(clk), .i_rst(rst), .o_clk(o_vec[0]));
  clock_div #(.I_CLK_FRQ(10), .FREQUENCY(3)) u_div_10_3 (.i_clk(clk), .i_rst(rst), .o_clk(o_vec[1]));
  clock_div #(.I_CLK_FRQ(4),  .FREQUENCY(4)) u_div_4_4  (.i_clk(clk), .i_rst(rst), .o_clk(o_vec[2]));
  clock_div #(.I_CLK_FRQ(4),  .FREQUENCY(0)) u_div_4_0  (.i_clk(clk), .i_rst(rst), .o_clk(o_vec[3]));
  clock_div #(.I_CLK_FRQ(4),  .FREQUENCY(6)) u_div_4_6  (.i_clk(clk), .i_rst(rst), .o_clk(o_vec[4]));
  clock_div u_div_dflt (.i_clk(clk), .i_rst(rst), .o_clk(o_vec[5]));

  // ---------------------------------------------------------------- scoreboard
  logic [N_DUT-1:0] exp_q[$];
  int               n_checks;
  int               n_fails;
  longint           k_edge;
  longint           pulse_cnt [N_DUT];
  string            dut_name [N_DUT] = '{"div_8_2", "div_10_3", "div_4_4",
                                         "div_4_0", "div_4_6", "div_dflt"};

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, k_edge, got, exp);
    end
  endtask

  // Expected strobe after edge k (k counted from 1 after reset release).
  function automatic logic exp_bit(input int idx, input longint k);
    longint i_f = I_TAB[idx];
    longint f   = F_TAB[idx];
    if (f >= i_f) return 1'b1;
    return ((k * f) / i_f) != (((k - 1) * f) / i_f);
  endfunction

  // ---------------------------------------------------------------- driver tasks
  // Release reset on a falling edge and restart the edge/pulse bookkeeping.
  task automatic release_reset();
    @(negedge clk);
    rst    = 1'b0;
    k_edge = 0;
    for (int j = 0; j < N_DUT; j++) pulse_cnt[j] = 0;
  endtask

  // Push the expectation at each rising edge, compare on the following falling edge.
  task automatic run_edges(input int n);
    logic [N_DUT-1:0] exp_v;
    logic [N_DUT-1:0] exp_next;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k_edge++;
      for (int j = 0; j < N_DUT; j++) exp_next[j] = exp_bit(j, k_edge);
      exp_q.push_back(exp_next);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      for (int j = 0; j < N_DUT; j++) begin
        check_val(dut_name[j], longint'(o_vec[j]), longint'(exp_v[j]));
        if (o_vec[j]) pulse_cnt[j]++;
      end
      check_val("acc_4_4", longint'(u_div_4_4.acc_q), 0);
      check_val("acc_4_0", longint'(u_div_4_0.acc_q), 0);
      check_val("acc_4_6", longint'(u_div_4_6.acc_q), 0);
    end
  endtask

  // Total pulses over the edges since release must be floor(K*F/I).
  task automatic check_counts();
    longint want;
    for (int j = 0; j < N_DUT; j++) begin
      if (F_TAB[j] >= I_TAB[j]) want = k_edge;
      else want = (k_edge * F_TAB[j]) / I_TAB[j];
      check_val({"count_", dut_name[j]}, pulse_cnt[j], want);
    end
  endtask

  // Assert reset between edges; outputs must drop before any further edge.
  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < N_DUT; j++) check_val({tag, "_", dut_name[j]}, longint'(o_vec[j]), 0);
    check_val({tag, "_acc_10_3"}, longint'(u_div_10_3.acc_q), 0);
    check_val({tag, "_acc_8_2"}, longint'(u_div_8_2.acc_q), 0);
    @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < N_DUT; j++) check_val({tag, "_hold_", dut_name[j]}, longint'(o_vec[j]), 0);
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    n_checks = 0;
    n_fails  = 0;
    k_edge   = 0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    for (int j = 0; j < N_DUT; j++) check_val({"reset_", dut_name[j]}, longint'(o_vec[j]), 0);

    // Long run covers the first two default-rate pulses (edge 10417 onward).
    release_reset();
    run_edges(21000);
    check_counts();

    // Reset while div_8_2 is mid-pulse (high after edge 4), then restart.
    async_reset_check("rst_idle");
    release_reset();
    run_edges(4);
    check_val("pulse_before_rst", longint'(o_vec[0]), 1);
    async_reset_check("rst_in_pulse");
    release_reset();
    run_edges(20);
    check_counts();

    // Reset between edges 6 and 7 of div_10_3; next pulse lands after edge 4.
    async_reset_check("rst_pre");
    release_reset();
    run_edges(6);
    async_reset_check("rst_e6");
    release_reset();
    run_edges(12);
    check_counts();

    check_val("exp_q_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard stop in case the sequence stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of sequence, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
